star_tally: RTL
===============

Name: star_tally

Overview:
- Consumer end of the star-collectible touch interface. Each star object raises a sticky `touch_star` level when the character overlaps it. This block turns those levels into collection events.
- It keeps a running collected-star count, drives a HUD flash timer, and flags level completion when every star is taken.
- Sits between the star objects and the HUD/score renderer in game_calc.

Parameters:
- NUM_STARS, 4, number of star objects feeding this block (1..15).
- COUNT_W, 4, width of star_count; must satisfy 2^COUNT_W > NUM_STARS.
- FLASH_FRAMES, 30, frame ticks the HUD flash lasts after a collection.
- FRAME_W, 6, width of the flash frame counter; must hold FLASH_FRAMES.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- touch_star  input  NUM_STARS  sticky touch levels, bit i from star object i.
- frame_tick  input  1  one-cycle pulse per video frame (vsync-derived).
- game_restart  input  1  one-cycle pulse; clears tally, returns to IDLE.
- star_count  output  COUNT_W  stars collected since reset/restart, registered.
- new_star  output  1  one-cycle pulse, the cycle after a new collection is detected.
- last_star_id  output  4  index of the most recently collected star.
- flash_active  output  1  HUD highlight/blink enable.
- all_collected  output  1  sticky; high once star_count == NUM_STARS.

Behaviour:
- Reset (RST high, asynchronous) sets:
  - star_count=0, new_star=0, last_star_id=0, flash_active=0, all_collected=0.
  - touch_prev=0, frame counter=0, state=IDLE.
- Edge detect:
  - touch_prev <= touch_star every cycle.
  - rise = touch_star & ~touch_prev.
  - Only rising edges count. A held level never recounts.
- On a cycle where rise != 0, these take effect the next cycle (1-cycle latency):
  - star_count += popcount(rise), saturating at NUM_STARS.
  - new_star=1 for exactly one cycle.
  - last_star_id = lowest set index in rise.
- Simultaneous rises: all are counted in one cycle. new_star still pulses once.
- State machine, 2-bit encoding, default branch goes to IDLE:
  - IDLE:
    - On rise with updated count < NUM_STARS → FLASH; load counter = FLASH_FRAMES.
    - On rise with updated count == NUM_STARS → DONE.
  - FLASH:
    - flash_active=1.
    - Each frame_tick decrements the counter. Reaching 0 → IDLE, flash_active=0 the same cycle.
    - A new rise reloads the counter to FLASH_FRAMES (or moves to DONE if the count completes).
    - frame_tick together with a rise: the reload wins.
  - DONE:
    - all_collected=1, held.
    - flash_active toggles on each frame_tick (blink).
    - Further rises have no effect: count is saturated and new_star stays 0.
- game_restart, any state:
  - Next cycle: star_count=0, all_collected=0, flash_active=0, counter=0, state=IDLE.
  - touch_prev still samples touch_star, so touch levels that are still high after a restart are not recounted.
  - If game_restart and a rise occur in the same cycle, restart wins and the rise is discarded.
- Widths:
  - popcount is computed at COUNT_W+1 bits, then compared and saturated.
  - bg_pos is not involved; the block is position-independent.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_FLASH=2'd1, ST_DONE=2'd2.
  - FLASH_FRAMES default.
  - NUM_STARS for the current level.
- One natural sub-module: star_edge_popcount. It is combinational and produces popcount(rise) and the lowest-set index from rise.

Test Plan:
- Reset, then raise touch_star[2] at cycle 10 and hold → star_count=1 and new_star=1 at cycle 11 only; last_star_id=2; flash_active=1; after 30 frame_ticks flash_active=0 and state=IDLE.
- Raise touch_star[0] and touch_star[3] in the same cycle → star_count jumps 0→2 in one cycle; single new_star pulse; last_star_id=0.
- In FLASH with counter=5, raise touch_star[1] together with frame_tick → counter reloads to 30; flash_active stays 1 for 30 more ticks.
- Raise all 4 stars one by one → all_collected=1 the cycle after the 4th rise; flash_active toggles on each frame_tick; further toggling of touch_star leaves star_count=4.
- With all 4 touch levels still high, pulse game_restart → star_count=0, all_collected=0, no new_star over the next 100 cycles.
- Assert RST mid-FLASH, asynchronous to sys_clk → all outputs 0 immediately; after release, the already-high touch levels are seen as rises on the first sampled edge (touch_prev=0).

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants and star_tally state encoding
//
// Purpose: state encoding for the star tally FSM and default level
// constants (stars in the current level, HUD flash length in frames).
// Ports: none (package).
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int LEVEL_NUM_STARS  = 4;
  localparam int DEF_FLASH_FRAMES = 30;

endpackage

// File: rtl/star_edge_popcount.sv
// rtl/star_edge_popcount.sv - popcount and lowest set index of a star rise vector
//
// Purpose: combinational helper for star_tally; counts newly touched stars
// and reports the lowest index among them.
// Ports:
//   rise_i     in  [N-1:0]  rising-edge vector, bit i from star i
//   pop_o      out [CW:0]   number of set bits in rise_i
//   low_idx_o  out [3:0]    lowest set index in rise_i (0 when none set)
module star_edge_popcount #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic [N-1:0] rise_i,
  output logic [CW:0]  pop_o,
  output logic [3:0]   low_idx_o
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    pop_o     = '0;
    low_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rise_i[i]) begin
        pop_o     = pop_o + (CW + 1)'(1);
        low_idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/star_tally.sv
// rtl/star_tally.sv - collected-star counter, HUD flash timer and level-complete flag
//
// Purpose: turns sticky per-star touch levels into collection events,
// keeps a saturating collected count, runs the HUD flash timer and
// raises a sticky level-complete flag.
// Ports:
//   sys_clk        in   system clock, rising edge
//   RST            in   asynchronous active-high reset
//   touch_star     in   [NUM_STARS-1:0] sticky touch levels
//   frame_tick     in   one-cycle pulse per video frame
//   game_restart   in   one-cycle pulse, clears the tally
//   star_count     out  [COUNT_W-1:0] stars collected
//   new_star       out  one-cycle pulse after a collection
//   last_star_id   out  [3:0] index of most recent collection
//   flash_active   out  HUD highlight / blink enable
//   all_collected  out  sticky, every star taken
module star_tally
  import game_pkg::*;
#(
  parameter int NUM_STARS    = LEVEL_NUM_STARS,
  parameter int COUNT_W      = 4,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
  parameter int FRAME_W      = 6
) (
  input  logic                 sys_clk,
  input  logic                 RST,
  input  logic [NUM_STARS-1:0] touch_star,
  input  logic                 frame_tick,
  input  logic                 game_restart,
  output logic [COUNT_W-1:0]   star_count,
  output logic                 new_star,
  output logic [3:0]           last_star_id,
  output logic                 flash_active,
  output logic                 all_collected
);

  localparam logic [COUNT_W:0]   NUM_W     = (COUNT_W + 1)'(NUM_STARS);
  localparam logic [FRAME_W-1:0] FRAMES_LD = FRAME_W'(FLASH_FRAMES);

  state_t               state_q, state_d;
  logic [NUM_STARS-1:0] touch_prev_q;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 new_q, new_d;
  logic [3:0]           last_q, last_d;
  logic                 flash_q, flash_d;
  logic                 all_q, all_d;
  logic [FRAME_W-1:0]   frames_q, frames_d;

  logic [NUM_STARS-1:0] rise;
  logic [COUNT_W:0]     pop;
  logic [3:0]           low_idx;
  logic [COUNT_W:0]     sum;
  logic [COUNT_W-1:0]   sat_count;
  logic                 hit;
  logic                 completes;

  assign rise = touch_star & ~touch_prev_q;

  star_edge_popcount #(
    .N  (NUM_STARS),
    .CW (COUNT_W)
  ) u_edge (
    .rise_i    (rise),
    .pop_o     (pop),
    .low_idx_o (low_idx)
  );

  // Sum is one bit wider than the count so it cannot wrap before saturation.
  assign sum       = {1'b0, count_q} + pop;
  assign sat_count = (sum >= NUM_W) ? NUM_W[COUNT_W-1:0] : sum[COUNT_W-1:0];
  assign completes = (sum >= NUM_W);
  // Once DONE the tally is frozen; restart discards any coincident rise.
  assign hit = (|rise) && !game_restart &&
               ((state_q == ST_IDLE) || (state_q == ST_FLASH));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    new_d    = 1'b0;
    last_d   = last_q;
    flash_d  = flash_q;
    all_d    = all_q;
    frames_d = frames_q;
    if (game_restart) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      flash_d  = 1'b0;
      all_d    = 1'b0;
      frames_d = '0;
    end else if (hit) begin
      // A rise outranks a coincident frame_tick: the timer reloads.
      count_d = sat_count;
      new_d   = 1'b1;
      last_d  = low_idx;
      flash_d = 1'b1;
      if (completes) begin
        state_d  = ST_DONE;
        all_d    = 1'b1;
        frames_d = '0;
      end else begin
        state_d  = ST_FLASH;
        frames_d = FRAMES_LD;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FLASH: begin
          if (frame_tick) begin
            if (frames_q <= FRAME_W'(1)) begin
              frames_d = '0;
              state_d  = ST_IDLE;
              flash_d  = 1'b0;
            end else begin
              frames_d = frames_q - FRAME_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (frame_tick) flash_d = ~flash_q;
        end
        default: begin
          state_d  = ST_IDLE;
          flash_d  = 1'b0;
          frames_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      touch_prev_q <= '0;
      count_q      <= '0;
      new_q        <= 1'b0;
      last_q       <= '0;
      flash_q      <= 1'b0;
      all_q        <= 1'b0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      touch_prev_q <= touch_star;
      count_q      <= count_d;
      new_q        <= new_d;
      last_q       <= last_d;
      flash_q      <= flash_d;
      all_q        <= all_d;
      frames_q     <= frames_d;
    end
  end

  assign star_count    = count_q;
  assign new_star      = new_q;
  assign last_star_id  = last_q;
  assign flash_active  = flash_q;
  assign all_collected = all_q;

endmodule
